// File: rtl/datapath_step_sequencer.sv
// Control-step sequencer for the phase-1 datapath (T0..T6, register-register ops).
// Optional mem_ready watchdog is built only when SEQ_TIMEOUT_EN is defined.
module datapath_step_sequencer #(
   parameter logic [4:0]  MUL_OPCODE     = 5'b01111,
   parameter logic [4:0]  DIV_OPCODE     = 5'b10000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic [4:0]  opcode,
   input  logic [3:0]  ra,
   input  logic [3:0]  rb,
   input  logic [3:0]  rc,
   input  logic        mem_ready,
   output logic [4:0]  bus_sel,
   output logic [15:0] reg_in,
   output logic        pc_in,
   output logic        ir_in,
   output logic        mar_in,
   output logic        mdr_in,
   output logic        y_in,
   output logic        z_in,
   output logic        hi_in,
   output logic        lo_in,
   output logic        inc_pc,
   output logic        mem_read,
   output logic [4:0]  alu_op,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_ERR
   } state_t;

   state_t state_q, state_d;
   logic   first_q, first_d;
   logic   is_md;

   assign is_md = (opcode == MUL_OPCODE) || (opcode == DIV_OPCODE);

`ifdef SEQ_TIMEOUT_EN
   logic [4:0] cnt_q, cnt_d;
   logic       expired;

   assign expired = (cnt_q == 5'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == S_T0)
         cnt_d = '0;
      else if (state_q == S_T1 && !mem_ready)
         cnt_d = cnt_q + 5'd1;
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

   always_comb begin
      state_d = state_q;
      first_d = (state_q == S_T0);
      unique case (state_q)
         S_IDLE: if (start) state_d = S_T0;
         S_T0:   state_d = S_T1;
         S_T1: begin
            if (mem_ready)
               state_d = S_T2;
`ifdef SEQ_TIMEOUT_EN
            else if (expired)
               state_d = S_ERR;
`endif
         end
         S_T2:   state_d = S_T3;
         S_T3:   state_d = S_T4;
         S_T4:   state_d = S_T5;
         // the final step relaunches directly when start is still held
         S_T5:   state_d = is_md ? S_T6 : (start ? S_T0 : S_IDLE);
         S_T6:   state_d = start ? S_T0 : S_IDLE;
         S_ERR:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= S_IDLE;
         first_q <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         first_q <= first_d;
`ifdef SEQ_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   always_comb begin
      bus_sel  = 5'd0;
      reg_in   = 16'd0;
      pc_in    = 1'b0;
      ir_in    = 1'b0;
      mar_in   = 1'b0;
      mdr_in   = 1'b0;
      y_in     = 1'b0;
      z_in     = 1'b0;
      hi_in    = 1'b0;
      lo_in    = 1'b0;
      inc_pc   = 1'b0;
      mem_read = 1'b0;
      alu_op   = 5'd0;
      done     = 1'b0;
      err      = 1'b0;
      busy     = (state_q != S_IDLE);
      unique case (state_q)
         S_T0: begin
            bus_sel = 5'd20;
            mar_in  = 1'b1;
            inc_pc  = 1'b1;
            z_in    = 1'b1;
         end
         S_T1: begin
            bus_sel  = 5'd19;
            pc_in    = first_q;
            mem_read = 1'b1;
            mdr_in   = 1'b1;
         end
         S_T2: begin
            bus_sel = 5'd21;
            ir_in   = 1'b1;
         end
         S_T3: begin
            bus_sel = {1'b0, rb};
            y_in    = 1'b1;
         end
         S_T4: begin
            bus_sel = {1'b0, rc};
            alu_op  = opcode;
            z_in    = 1'b1;
         end
         S_T5: begin
            bus_sel = 5'd19;
            if (is_md) begin
               lo_in = 1'b1;
            end else begin
               reg_in = 16'd1 << ra;
               done   = 1'b1;
            end
         end
         S_T6: begin
            bus_sel = 5'd18;
            hi_in   = 1'b1;
            done    = 1'b1;
         end
         S_ERR: begin
`ifdef SEQ_TIMEOUT_EN
            err = 1'b1;
`endif
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_datapath_step_sequencer.sv
// Bench for datapath_step_sequencer: table vectors, corner sequences, random ops.
// Expected traces are built per instruction from the step rules.
module tb_datapath_step_sequencer;

   logic        clock = 1'b0;
   logic        clear = 1'b1;
   logic        start = 1'b0;
   logic        mem_ready = 1'b0;
   logic [4:0]  opcode = 5'd0;
   logic [3:0]  ra = 4'd0;
   logic [3:0]  rb = 4'd0;
   logic [3:0]  rc = 4'd0;
   logic [4:0]  bus_sel;
   logic [15:0] reg_in;
   logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in;
   logic        inc_pc, mem_read;
   logic [4:0]  alu_op;
   logic        busy, done, err;

   localparam logic [4:0] MUL = 5'b01111;
   localparam logic [4:0] DIV = 5'b10000;
   localparam logic [7:0] LD_PC  = 8'h80;
   localparam logic [7:0] LD_IR  = 8'h40;
   localparam logic [7:0] LD_MAR = 8'h20;
   localparam logic [7:0] LD_MDR = 8'h10;
   localparam logic [7:0] LD_Y   = 8'h08;
   localparam logic [7:0] LD_Z   = 8'h04;
   localparam logic [7:0] LD_HI  = 8'h02;
   localparam logic [7:0] LD_LO  = 8'h01;

   datapath_step_sequencer dut (
      .clock(clock), .clear(clear), .start(start),
      .opcode(opcode), .ra(ra), .rb(rb), .rc(rc),
      .mem_ready(mem_ready), .bus_sel(bus_sel), .reg_in(reg_in),
      .pc_in(pc_in), .ir_in(ir_in), .mar_in(mar_in), .mdr_in(mdr_in),
      .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in),
      .inc_pc(inc_pc), .mem_read(mem_read), .alu_op(alu_op),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [4:0]  sel;
      logic [15:0] rin;
      logic [7:0]  ld;
      logic        inc;
      logic        rd;
      logic [4:0]  alu;
      logic        busy;
      logic        done;
      logic        err;
   } obs_t;

   obs_t obs;
   assign obs = {bus_sel, reg_in,
                 {pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in},
                 inc_pc, mem_read, alu_op, busy, done, err};

   typedef struct {
      logic [4:0]  op;
      logic [3:0]  a, b, c;
      int          waits;
      int          lat;
      logic [15:0] rin;
   } vec_t;

   obs_t exp_q[$];
   vec_t vt[7];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [63:0] got,
                        input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic push(input logic [4:0] sel, input logic [15:0] rin,
                       input logic [7:0] ld, input logic inc, input logic rd,
                       input logic [4:0] alu, input logic dn, input logic er);
      obs_t e;
      e.sel = sel; e.rin = rin; e.ld = ld; e.inc = inc; e.rd = rd;
      e.alu = alu; e.busy = 1'b1; e.done = dn; e.err = er;
      exp_q.push_back(e);
   endtask

   task automatic build(input logic [4:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] c,
                        input int waits);
      exp_q.delete();
      push(5'd20, 16'd0, LD_MAR | LD_Z, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      for (int i = 0; i <= waits; i++)
         push(5'd19, 16'd0, (i == 0 ? LD_PC : 8'h00) | LD_MDR,
              1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
      push(5'd21, 16'd0, LD_IR, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      push({1'b0, b}, 16'd0, LD_Y, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      push({1'b0, c}, 16'd0, LD_Z, 1'b0, 1'b0, op, 1'b0, 1'b0);
      if (op == MUL || op == DIV) begin
         push(5'd19, 16'd0, LD_LO, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
         push(5'd18, 16'd0, LD_HI, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      end else begin
         push(5'd19, 16'd1 << a, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      end
   endtask

   task automatic run_op(input logic [4:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] c,
                         input int waits, input bit hold, input int pulse_at,
                         output int done_at, output logic [15:0] rin_at);
      build(op, a, b, c, waits);
      done_at = 0;
      rin_at  = 16'd0;
      @(posedge clock); #1;
      start = 1'b1; opcode = op; ra = a; rb = b; rc = c; mem_ready = 1'b0;
      @(negedge clock);
      check("idle before op", obs, 64'd0);
      for (int k = 1; k <= exp_q.size(); k++) begin
         @(posedge clock); #1;
         start = hold || (k == pulse_at);
         mem_ready = (k >= 2 + waits);
         @(negedge clock);
         check($sformatf("trace op=%0h cyc=%0d", op, k), obs, exp_q[k-1]);
         if (done === 1'b1 && done_at == 0) begin
            done_at = k;
            rin_at  = reg_in;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          d;
      logic [15:0] r;
      logic [4:0]  op;
      int          w;
      bit          md;

      vt[0] = '{5'b00011, 4'd2,  4'd4,  4'd5,  0,  6, 16'h0004};
      vt[1] = '{5'b00011, 4'd9,  4'd1,  4'd3,  3,  9, 16'h0200};
      vt[2] = '{MUL,      4'd3,  4'd6,  4'd7,  0,  7, 16'h0000};
      vt[3] = '{DIV,      4'd15, 4'd2,  4'd8,  1,  8, 16'h0000};
      vt[4] = '{5'b00000, 4'd0,  4'd0,  4'd0,  0,  6, 16'h0001};
      vt[5] = '{5'b11111, 4'd15, 4'd15, 4'd0,  2,  8, 16'h8000};
      vt[6] = '{5'b00101, 4'd7,  4'd12, 4'd13, 12, 18, 16'h0080};

      clear = 1'b1;
      repeat (2) begin
         @(negedge clock);
         check("reset outputs", obs, 64'd0);
      end
      @(posedge clock); #1;
      clear = 1'b0;

      foreach (vt[i]) begin
         run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].c, vt[i].waits,
                1'b0, 0, d, r);
         check($sformatf("latency vec%0d", i), 64'(d), 64'(vt[i].lat));
         check($sformatf("reg_in vec%0d", i), 64'(r), 64'(vt[i].rin));
      end

      // clear in T3, then clear together with start
      @(posedge clock); #1;
      start = 1'b1; opcode = 5'b00011; ra = 4'd1; rb = 4'd9; rc = 4'd10;
      mem_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clock); #1;
         start = 1'b0;
         @(negedge clock);
      end
      check("T3 bus_sel", 64'(obs.sel), 64'd9);
      clear = 1'b1;
      start = 1'b1;
      @(negedge clock);
      check("clear from T3", obs, 64'd0);
      @(negedge clock);
      check("clear beats start", obs, 64'd0);
      clear = 1'b0;
      start = 1'b0;
      repeat (3) begin
         @(negedge clock);
         check("no writeback after clear", obs, 64'd0);
      end

      // start pulse during T4 must be ignored
      run_op(5'b00011, 4'd6, 4'd3, 4'd4, 0, 1'b0, 5, d, r);
      check("latency start-in-T4", 64'(d), 64'd6);

      // back-to-back with start held, ra=0
      run_op(5'b00011, 4'd0, 4'd1, 4'd2, 0, 1'b1, 0, d, r);
      check("b2b latency", 64'(d), 64'd6);
      check("b2b reg_in", 64'(r), 64'h0001);
      build(5'b00011, 4'd0, 4'd1, 4'd2, 0);
      @(posedge clock); #1;
      start = 1'b0;
      @(negedge clock);
      check("b2b T0 re-entry", obs, exp_q[0]);
      for (int k = 2; k <= exp_q.size(); k++) begin
         @(posedge clock); #1;
         @(negedge clock);
         check($sformatf("b2b second cyc=%0d", k), obs, exp_q[k-1]);
      end

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0)
            op = ($urandom_range(0, 1) == 1) ? MUL : DIV;
         else
            op = 5'($urandom);
         md = (op == MUL) || (op == DIV);
         w  = $urandom_range(0, 5);
         ra = 4'($urandom);
         run_op(op, ra, 4'($urandom), 4'($urandom), w, 1'b0, 0, d, r);
         check($sformatf("rand latency %0d", n), 64'(d),
               64'(6 + w + (md ? 1 : 0)));
         check($sformatf("rand reg_in %0d", n), 64'(r),
               md ? 64'd0 : 64'(16'd1 << ra));
      end

`ifdef SEQ_TIMEOUT_EN
      exp_q.delete();
      push(5'd20, 16'd0, LD_MAR | LD_Z, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++)
         push(5'd19, 16'd0, (i == 0 ? LD_PC : 8'h00) | LD_MDR,
              1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
      push(5'd0, 16'd0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      @(posedge clock); #1;
      start = 1'b1;
      mem_ready = 1'b0;
      for (int k = 1; k <= exp_q.size(); k++) begin
         @(posedge clock); #1;
         start = 1'b0;
         @(negedge clock);
         check($sformatf("timeout cyc=%0d", k), obs, exp_q[k-1]);
      end
      @(negedge clock);
      check("idle after timeout", obs, 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
